// File: rtl/exe_alu_datapath.sv
// MIPS32 integer execute stage: operand select, 32-bit ALU with signed overflow,
// AO/RT result muxes and the EXE/MEM output register. Define EXE_ALU_CLZ_EN to enable CLZ (code 14).
module exe_alu_datapath #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 stall,
  input  logic [WIDTH-1:0]     rs_val,
  input  logic [WIDTH-1:0]     rt_val,
  input  logic [WIDTH-1:0]     ext_imm,
  input  logic                 alua_sel,
  input  logic                 alub_sel,
  input  logic [3:0]           alu_func,
  input  logic [1:0]           aom_sel,
  input  logic [1:0]           rtm_sel,
  input  logic [2*WIDTH-1:0]   div_res,
  input  logic [2*WIDTH-1:0]   mult_res,
  output logic [WIDTH-1:0]     alu_out,
  output logic                 overflow,
  output logic [WIDTH-1:0]     aom_q,
  output logic [WIDTH-1:0]     rtm_q,
  output logic                 ovf_q,
  output logic                 out_valid
);

  localparam logic [3:0] OP_ADDU  = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUBU  = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_NOR   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_SLL   = 4'd10;
  localparam logic [3:0] OP_SRL   = 4'd11;
  localparam logic [3:0] OP_SRA   = 4'd12;
  localparam logic [3:0] OP_LUI   = 4'd13;
  localparam logic [3:0] OP_CLZ   = 4'd14;
  localparam logic [3:0] OP_PASSB = 4'd15;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] alu_res;
  logic             ovf_res;
  logic [WIDTH-1:0] aom_mux;
  logic [WIDTH-1:0] rtm_mux;

  logic [WIDTH-1:0] aom_d;
  logic [WIDTH-1:0] rtm_d;
  logic             ovf_d;
  logic             out_valid_d;
  logic             out_valid_q;

  always_comb begin
    op_a  = alua_sel ? ext_imm : rs_val;
    op_b  = alub_sel ? ext_imm : rt_val;
    sum   = op_a + op_b;
    diff  = op_a - op_b;
    shamt = op_a[4:0];
  end

`ifdef EXE_ALU_CLZ_EN
  logic [5:0] clz_cnt;

  // Scanning upward lets the highest set bit win, leaving the leading-zero count.
  always_comb begin
    clz_cnt = 6'd32;
    for (int i = 0; i < WIDTH; i++) begin
      if (op_a[i]) clz_cnt = 6'(WIDTH - 1 - i);
    end
  end
`endif

  always_comb begin
    alu_res = '0;
    ovf_res = 1'b0;
    case (alu_func)
      OP_ADDU:  alu_res = sum;
      OP_ADD: begin
        alu_res = sum;
        ovf_res = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUBU:  alu_res = diff;
      OP_SUB: begin
        alu_res = diff;
        ovf_res = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND:   alu_res = op_a & op_b;
      OP_OR:    alu_res = op_a | op_b;
      OP_XOR:   alu_res = op_a ^ op_b;
      OP_NOR:   alu_res = ~(op_a | op_b);
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      OP_SLL:   alu_res = op_b << shamt;
      OP_SRL:   alu_res = op_b >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(op_b) >>> shamt);
      OP_LUI:   alu_res = {op_b[15:0], 16'h0000};
      OP_CLZ: begin
`ifdef EXE_ALU_CLZ_EN
        alu_res = {{(WIDTH-6){1'b0}}, clz_cnt};
`else
        alu_res = '0;
`endif
      end
      OP_PASSB: alu_res = op_b;
      default:  alu_res = '0;
    endcase
  end

  assign alu_out  = alu_res;
  assign overflow = ovf_res;

  // Select value 3 falls back to the primary source so no encoding produces X.
  always_comb begin
    case (aom_sel)
      2'd1:    aom_mux = div_res[WIDTH-1:0];
      2'd2:    aom_mux = mult_res[2*WIDTH-1:WIDTH];
      default: aom_mux = alu_res;
    endcase
    case (rtm_sel)
      2'd1:    rtm_mux = div_res[2*WIDTH-1:WIDTH];
      2'd2:    rtm_mux = mult_res[WIDTH-1:0];
      default: rtm_mux = rt_val;
    endcase
  end

  // Reset beats stall; data registers load regardless of in_valid.
  always_comb begin
    aom_d       = aom_q;
    rtm_d       = rtm_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    if (reset) begin
      aom_d       = '0;
      rtm_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else if (!stall) begin
      aom_d       = aom_mux;
      rtm_d       = rtm_mux;
      ovf_d       = ovf_res & in_valid;
      out_valid_d = in_valid;
    end
  end

  always_ff @(posedge clk) begin
    aom_q       <= aom_d;
    rtm_q       <= rtm_d;
    ovf_q       <= ovf_d;
    out_valid_q <= out_valid_d;
  end

  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_exe_alu_datapath.sv
// Directed scoreboard bench for exe_alu_datapath: combinational ALU results are checked
// immediately, registered results are queued at drive time and popped after the clock edge.
module tb_exe_alu_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        stall;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] ext_imm;
  logic        alua_sel;
  logic        alub_sel;
  logic [3:0]  alu_func;
  logic [1:0]  aom_sel;
  logic [1:0]  rtm_sel;
  logic [63:0] div_res;
  logic [63:0] mult_res;
  logic [31:0] alu_out;
  logic        overflow;
  logic [31:0] aom_q;
  logic [31:0] rtm_q;
  logic        ovf_q;
  logic        out_valid;

  typedef struct {
    logic [31:0] aom;
    logic [31:0] rtm;
    logic        ovf;
    logic        valid;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   checks = 0;
  int   errors = 0;

  exe_alu_datapath #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .stall     (stall),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .ext_imm   (ext_imm),
    .alua_sel  (alua_sel),
    .alub_sel  (alub_sel),
    .alu_func  (alu_func),
    .aom_sel   (aom_sel),
    .rtm_sel   (rtm_sel),
    .div_res   (div_res),
    .mult_res  (mult_res),
    .alu_out   (alu_out),
    .overflow  (overflow),
    .aom_q     (aom_q),
    .rtm_q     (rtm_q),
    .ovf_q     (ovf_q),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Pops the oldest expected register state and compares it with the DUT registers.
  task automatic checkOutput(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("[TB] FAIL %s_queue observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (aom_q === e.aom) else begin
        errors++;
        $error("[TB] FAIL %s_aom observed=%h expected=%h", tag, aom_q, e.aom);
      end
      checks++;
      assert (rtm_q === e.rtm) else begin
        errors++;
        $error("[TB] FAIL %s_rtm observed=%h expected=%h", tag, rtm_q, e.rtm);
      end
      checks++;
      assert (ovf_q === e.ovf) else begin
        errors++;
        $error("[TB] FAIL %s_ovfq observed=%b expected=%b", tag, ovf_q, e.ovf);
      end
      checks++;
      assert (out_valid === e.valid) else begin
        errors++;
        $error("[TB] FAIL %s_valid observed=%b expected=%b", tag, out_valid, e.valid);
      end
    end
  endtask

  // Drives one unstalled instruction, checks the combinational ALU, queues the register result.
  task automatic applyStimulus(
    input string       tag,
    input logic        valid,
    input logic [3:0]  func,
    input logic        a_sel,
    input logic        b_sel,
    input logic [31:0] rs,
    input logic [31:0] rt,
    input logic [31:0] imm,
    input logic [1:0]  ao_sel,
    input logic [1:0]  rt_sel,
    input logic [63:0] div,
    input logic [63:0] mult,
    input logic [31:0] exp_alu,
    input logic        exp_ovf,
    input logic [31:0] exp_aom,
    input logic [31:0] exp_rtm
  );
    exp_t e;
    @(negedge clk);
    stall    = 1'b0;
    in_valid = valid;
    alu_func = func;
    alua_sel = a_sel;
    alub_sel = b_sel;
    rs_val   = rs;
    rt_val   = rt;
    ext_imm  = imm;
    aom_sel  = ao_sel;
    rtm_sel  = rt_sel;
    div_res  = div;
    mult_res = mult;
    #1;
    checks++;
    assert (alu_out === exp_alu) else begin
      errors++;
      $error("[TB] FAIL %s_alu observed=%h expected=%h", tag, alu_out, exp_alu);
    end
    checks++;
    assert (overflow === exp_ovf) else begin
      errors++;
      $error("[TB] FAIL %s_ovf observed=%b expected=%b", tag, overflow, exp_ovf);
    end
    e.aom   = exp_aom;
    e.rtm   = exp_rtm;
    e.ovf   = exp_ovf & valid;
    e.valid = valid;
    sb.push_back(e);
    last_exp = e;
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    exp_t z;
    logic [31:0] clz_a, clz_zero;
    z.aom = '0; z.rtm = '0; z.ovf = 1'b0; z.valid = 1'b0;
`ifdef EXE_ALU_CLZ_EN
    clz_a    = 32'd15;
    clz_zero = 32'd32;
`else
    clz_a    = 32'd0;
    clz_zero = 32'd0;
`endif

    reset = 1'b1; stall = 1'b0; in_valid = 1'b0;
    rs_val = '0; rt_val = '0; ext_imm = '0; alua_sel = 1'b0; alub_sel = 1'b0;
    alu_func = '0; aom_sel = '0; rtm_sel = '0; div_res = '0; mult_res = '0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(z);
    checkOutput("reset");
    @(negedge clk);
    reset = 1'b0;

    //           tag        vld func  as    bs    rs            rt            imm           ao    rt    div                     mult                    alu           ovf   aom           rtm
    applyStimulus("add_ovf", 1, 4'd1, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h0, 2'd0, 2'd0, 64'h0, 64'h0, 32'h80000000, 1'b1, 32'h80000000, 32'h00000001);
    applyStimulus("addu",    1, 4'd0, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h0, 2'd0, 2'd0, 64'h0, 64'h0, 32'h80000000, 1'b0, 32'h80000000, 32'h00000001);
    applyStimulus("add_neg", 1, 4'd1, 1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 2'd0, 2'd0, 64'h0, 64'h0, 32'h7FFFFFFF, 1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF);
    applyStimulus("sub_ovf", 1, 4'd3, 1'b0, 1'b0, 32'h80000000, 32'h00000001, 32'h0, 2'd0, 2'd0, 64'h0, 64'h0, 32'h7FFFFFFF, 1'b1, 32'h7FFFFFFF, 32'h00000001);
    applyStimulus("subu",    1, 4'd2, 1'b0, 1'b0, 32'h00000005, 32'h00000007, 32'h0, 2'd0, 2'd0, 64'h0, 64'h0, 32'hFFFFFFFE, 1'b0, 32'hFFFFFFFE, 32'h00000007);
    applyStimulus("inv_ovf", 0, 4'd1, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h0, 2'd0, 2'd0, 64'h0, 64'h0, 32'h80000000, 1'b1, 32'h80000000, 32'h00000001);
    applyStimulus("slt",     1, 4'd8, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h0, 2'd0, 2'd0, 64'h0, 64'h0, 32'h00000001, 1'b0, 32'h00000001, 32'h00000001);
    applyStimulus("sltu",    1, 4'd9, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h0, 2'd0, 2'd0, 64'h0, 64'h0, 32'h00000000, 1'b0, 32'h00000000, 32'h00000001);
    applyStimulus("or",      1, 4'd5, 1'b0, 1'b0, 32'h0F0F0000, 32'h0000F0F0, 32'h0, 2'd0, 2'd0, 64'h0, 64'h0, 32'h0F0FF0F0, 1'b0, 32'h0F0FF0F0, 32'h0000F0F0);
    applyStimulus("xor",     1, 4'd6, 1'b0, 1'b0, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0, 2'd0, 2'd0, 64'h0, 64'h0, 32'hF0F00F0F, 1'b0, 32'hF0F00F0F, 32'h0F0F0F0F);
    applyStimulus("nor",     1, 4'd7, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 32'h0, 2'd0, 2'd0, 64'h0, 64'h0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 32'h00000000);
    applyStimulus("sll",     1, 4'd10,1'b0, 1'b0, 32'h0000001F, 32'h00000001, 32'h0, 2'd0, 2'd0, 64'h0, 64'h0, 32'h80000000, 1'b0, 32'h80000000, 32'h00000001);
    applyStimulus("sra",     1, 4'd12,1'b1, 1'b0, 32'h0,        32'h80000010, 32'h4, 2'd0, 2'd0, 64'h0, 64'h0, 32'hF8000001, 1'b0, 32'hF8000001, 32'h80000010);
    applyStimulus("srl",     1, 4'd11,1'b1, 1'b0, 32'h0,        32'h80000010, 32'h4, 2'd0, 2'd0, 64'h0, 64'h0, 32'h08000001, 1'b0, 32'h08000001, 32'h80000010);
    applyStimulus("srl_hi",  1, 4'd11,1'b1, 1'b0, 32'h0,        32'h80000010, 32'hFFFFFFE4, 2'd0, 2'd0, 64'h0, 64'h0, 32'h08000001, 1'b0, 32'h08000001, 32'h80000010);
    applyStimulus("lui",     1, 4'd13,1'b0, 1'b0, 32'h0,        32'h00001234, 32'h0, 2'd0, 2'd0, 64'h0, 64'h0, 32'h12340000, 1'b0, 32'h12340000, 32'h00001234);
    applyStimulus("passb",   1, 4'd15,1'b0, 1'b1, 32'h11111111, 32'h22222222, 32'hDEADBEEF, 2'd0, 2'd0, 64'h0, 64'h0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 32'h22222222);
    applyStimulus("mult",    1, 4'd0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0, 2'd2, 2'd2, 64'h0, 64'h00000001_00000002, 32'h0, 1'b0, 32'h00000001, 32'h00000002);
    applyStimulus("div",     1, 4'd0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0, 2'd1, 2'd1, 64'hAAAA5555_00000003, 64'h0, 32'h0, 1'b0, 32'h00000003, 32'hAAAA5555);
    applyStimulus("sel3",    1, 4'd4, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 2'd3, 2'd3, 64'h12345678_9ABCDEF0, 64'h0FEDCBA9_87654321, 32'hF000F000, 1'b0, 32'hF000F000, 32'hFF00FF00);
    applyStimulus("clz",     1, 4'd14,1'b0, 1'b0, 32'h00010000, 32'h0,        32'h0, 2'd0, 2'd0, 64'h0, 64'h0, clz_a, 1'b0, clz_a, 32'h0);
    applyStimulus("clz_0",   1, 4'd14,1'b0, 1'b0, 32'h00000000, 32'h0,        32'h0, 2'd0, 2'd0, 64'h0, 64'h0, clz_zero, 1'b0, clz_zero, 32'h0);
    applyStimulus("pre_stl", 1, 4'd1, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h0, 2'd0, 2'd0, 64'h0, 64'h0, 32'h80000000, 1'b1, 32'h80000000, 32'h00000001);

    // Held registers must ignore changing inputs while stalled.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      stall    = 1'b1;
      in_valid = i[0];
      rs_val   = $urandom;
      rt_val   = $urandom;
      alu_func = 4'(i + 4);
      aom_sel  = 2'(i + 1);
      rtm_sel  = 2'(i + 1);
      mult_res = {$urandom, $urandom};
      div_res  = {$urandom, $urandom};
      sb.push_back(last_exp);
      @(posedge clk);
      #1;
      checkOutput("stall");
    end

    @(negedge clk);
    reset    = 1'b1;
    stall    = 1'b1;
    in_valid = 1'b1;
    sb.push_back(z);
    @(posedge clk);
    #1;
    checkOutput("rst_stall");
    @(negedge clk);
    reset = 1'b0;

    applyStimulus("recover", 1, 4'd0, 1'b0, 1'b0, 32'h00000010, 32'h00000020, 32'h0, 2'd0, 2'd0, 64'h0, 64'h0, 32'h00000030, 1'b0, 32'h00000030, 32'h00000020);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_alu_datapath.md
Name: exe_alu_datapath

Overview:
- Integer execute-stage datapath of the MIPS32 pipeline: two 2:1 operand-select muxes, a 32-bit ALU with signed-overflow detect, and two 3:1 result-select muxes (AO and RT paths).
- Drives the EXE/MEM boundary through a one-stage output register with valid and stall.
- Operands arrive already forwarded; multiplier/divider results arrive as 64-bit inputs from their own units.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  current inputs are a valid instruction
- stall  in  1  hold the output registers
- rs_val  in  32  forwarded RS operand
- rt_val  in  32  forwarded RT operand
- ext_imm  in  32  extended immediate / shamt
- alua_sel  in  1  ALU A source: 0 = rs_val, 1 = ext_imm
- alub_sel  in  1  ALU B source: 0 = rt_val, 1 = ext_imm
- alu_func  in  4  ALU operation code
- aom_sel  in  2  AO result select
- rtm_sel  in  2  RT result select
- div_res  in  64  divider output; [63:32] = remainder, [31:0] = quotient
- mult_res  in  64  multiplier product
- alu_out  out  32  combinational ALU result
- overflow  out  1  combinational signed overflow
- aom_q  out  32  registered AO result
- rtm_q  out  32  registered RT result
- ovf_q  out  1  registered overflow
- out_valid  out  1  registered valid

Behaviour:
Operand selection (combinational):
- A = alua_sel ? ext_imm : rs_val.
- B = alub_sel ? ext_imm : rt_val.

ALU function codes (alu_func), all arithmetic mod 2^32:
- 0 ADDU: A+B
- 1 ADD: A+B, overflow checked
- 2 SUBU: A-B
- 3 SUB: A-B, overflow checked
- 4 AND, 5 OR, 6 XOR, 7 NOR
- 8 SLT: signed A<B, result 1 or 0
- 9 SLTU: unsigned A<B, result 1 or 0
- 10 SLL: B << A[4:0]
- 11 SRL: B >> A[4:0], logical
- 12 SRA: B >>> A[4:0], arithmetic
- 13 LUI: {B[15:0], 16'h0}
- 14: see Optional Feature
- 15 PASSB: B

Overflow:
- ADD: overflow = (A[31]==B[31]) && (sum[31]!=A[31]).
- SUB: overflow = (A[31]!=B[31]) && (diff[31]!=A[31]).
- All other codes: overflow = 0.
- alu_out still carries the wrapped result when overflow is set.

AO select (3:1):
- 0 = alu_out
- 1 = div_res[31:0]
- 2 = mult_res[63:32]
- 3 = alu_out (defined default)

RT select (3:1):
- 0 = rt_val
- 1 = div_res[63:32]
- 2 = mult_res[31:0]
- 3 = rt_val (defined default)

Output register, rising clk:
- reset: aom_q = 0, rtm_q = 0, ovf_q = 0, out_valid = 0. Reset has priority over stall.
- stall=1 (no reset): all registers hold.
- otherwise: aom_q and rtm_q load the mux outputs; ovf_q <= overflow & in_valid; out_valid <= in_valid.
- Data registers load even when in_valid=0. Consumers qualify data with out_valid.

Latency and boundaries:
- Latency is one cycle; throughput is one instruction per cycle when not stalled.
- Reset asserted mid-stream: any pending result is discarded.
- in_valid with stall: the input is not captured, and upstream must hold its inputs.
- Shift amount uses only A[4:0]; A[31:5] is ignored.
- No X propagation for any select value.

Optional Feature:
- Macro EXE_ALU_CLZ_EN.
- Defined: code 14 = CLZ, the count of leading zeros of A, range 0..32 (A=0 gives 32).
- Undefined: code 14 yields alu_out = 0 and overflow = 0.

Test Plan:
- ADD, A=32'h7FFFFFFF, B=1, sel 0/0 -> alu_out=32'h80000000, overflow=1; next cycle ovf_q=1, out_valid=1. Same inputs with ADDU -> overflow=0.
- SUB, A=32'h80000000, B=1 -> overflow=1. SLT with A=-1, B=1 -> 1. SLTU with the same operands -> 0.
- SRA, B=32'h80000010, alua_sel=1, ext_imm=4 -> 32'hF8000001. SRL with the same operands -> 32'h08000001. LUI with B=32'h00001234 -> 32'h12340000.
- aom_sel=2, rtm_sel=2, mult_res=64'h00000001_00000002 -> aom_q=1, rtm_q=2. Then sel 1/1 with div_res=64'hAAAA_5555 in the upper word and 32'h0000_0003 in the lower -> aom_q=3, rtm_q=32'hAAAA5555. sel=3 -> alu_out and rt_val respectively.
- Stall held for 2 cycles while inputs change -> outputs unchanged. Reset asserted together with stall -> all outputs 0 on the next edge.
- CLZ of A=32'h00010000 -> 15 with EXE_ALU_CLZ_EN defined, 0 without it. A=0 -> 32 with the macro defined.
